// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and the default
// bit period, used by uart_tx and a future uart_rx.
package uart_pkg;

   localparam int DATA_W               = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmit-side handshake between the TX FIFO controller (master) and the
// serial transmitter (slave): write strobe, byte, idle flag and line output.
interface uart_tx_if;
   import uart_pkg::*;

   logic              WR;
   logic [DATA_W-1:0] data;
   logic              TI;
   logic              txd;

   modport master (output WR, data, input TI, txd);
   modport slave  (input WR, data, output TI, txd);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// A synchronous clr restarts the period so every state begins with a full bit.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clock,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int                CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // tick is decoded from the counter alone, never from clr, so the FSM may
   // derive clr from its next state without forming a combinational loop.
   assign tick = (cnt == LAST);

   // Period counter: restart on clear or at terminal count, else advance.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tick) begin
         // NOTE: state uses non-blocking assignments so every register samples
         // pre-edge values; blocking here would create ordering-dependent races.
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: on a WR strobe in IDLE, sends start bit, 8 data bits
// LSB first, optional even parity bit and STOP_BITS stop bits on txd.
// TI is high only while idle. txd and TI are registered outputs.
// Optional feature: define UART_TX_PARITY_EN to insert the even parity bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input logic     clock,
   input logic     rst_n,
   uart_tx_if.slave bus
);

   localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_W - 1);
   localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BITS - 1);

   uart_state_e       state, state_next;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              txd_q, txd_d;
   logic              ti_q, ti_d;
   logic              tick;
   logic              baud_clr;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   // Restart the bit period on every state entry; hold it cleared while idle.
   assign baud_clr = (state_next != state) || (state == IDLE);

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clock (clock),
      .rst_n (rst_n),
      .clr   (baud_clr),
      .tick  (tick)
   );

   // Next state, shift register, bit counter and next values of the outputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; a missing default here would infer a latch.
      state_next = state;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state)
         IDLE: begin
            if (bus.WR) begin
               shift_d    = bus.data;
`ifdef UART_TX_PARITY_EN
               parity_d   = even_parity(bus.data);
`endif
               state_next = START;
            end
         end
         START: begin
            if (tick) state_next = DATA;
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) state_next = STOP;
         end
`endif
         STOP: begin
            // The bit counter is reused to count stop bits.
            if (tick) begin
               if (bit_cnt_q == LAST_STOP_BIT) begin
                  state_next = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (state_next != state) bit_cnt_d = '0;

      // Outputs follow the state being entered so they change on the same
      // edge as the state itself.
      ti_d = (state_next == IDLE);
      case (state_next)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  txd_d = parity_q;
`endif
         default: txd_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset forces the line idle immediately.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         txd_q     <= 1'b1;
         ti_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         txd_q     <= txd_d;
         ti_q      <= ti_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign bus.txd = txd_q;
   assign bus.TI  = ti_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (one and two stop bits) with
// CLKS_PER_BIT=4. Drivers push expected frames to per-instance queues; line
// monitors capture each frame bit by bit and compare against the queue head.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int N = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int F1 = N * (1 + 8 + P + 1);
   localparam int F2 = N * (1 + 8 + P + 2);

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   uart_tx_if bus0 ();
   uart_tx_if bus1 ();

   uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(1)) dut0 (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(2)) dut1 (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [11:0] q0[$];
   logic [11:0] q1[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic get_txd(input int u);
      return (u == 0) ? bus0.txd : bus1.txd;
   endfunction

   function automatic logic get_ti(input int u);
      return (u == 0) ? bus0.TI : bus1.TI;
   endfunction

   task automatic drive(input int u, input logic wr, input logic [7:0] d);
      if (u == 0) begin
         bus0.WR = wr; bus0.data = d;
      end else begin
         bus1.WR = wr; bus1.data = d;
      end
   endtask

   // Bit b of the result is the b-th bit on the line: start, d0..d7, [parity], stops.
   function automatic logic [11:0] frame_of(input logic [7:0] b, input int sb);
      logic [11:0] f;
      f      = '0;
      f[8:1] = b;
      if (P == 1) f[9] = ^b;
      for (int s = 0; s < sb; s++) f[9 + P + s] = 1'b1;
      return f;
   endfunction

   // An empty queue yields an all-ones frame, which can never match a real
   // frame (start bit is 0), so an unexpected frame shows up as a miscompare.
   function automatic logic [11:0] pop_exp(input int u);
      logic [11:0] e;
      e = '1;
      if (u == 0) begin
         if (q0.size() > 0) e = q0.pop_front();
      end else begin
         if (q1.size() > 0) e = q1.pop_front();
      end
      return e;
   endfunction

   task automatic monitor(input int u);
      int          nb;
      logic [11:0] act;
      logic [11:0] exp;
      logic        first;
      bit          glitch;
      bit          aborted;
      nb = 9 + P + ((u == 0) ? 1 : 2);
      forever begin
         @(negedge clock);
         if (rst_n === 1'b1 && get_txd(u) === 1'b0) begin
            act = '0; glitch = 0; aborted = 0; first = 1'b0;
            for (int b = 0; b < nb; b++) begin
               for (int c = 0; c < N; c++) begin
                  if (b != 0 || c != 0) @(negedge clock);
                  if (rst_n !== 1'b1) aborted = 1;
                  if (c == 0) first = get_txd(u);
                  else if (get_txd(u) !== first) glitch = 1;
               end
               act[b] = first;
               if (aborted) break;
            end
            exp = pop_exp(u);
            if (aborted) begin
               wait (rst_n === 1'b1);
            end else begin
               check($sformatf("frame_u%0d", u), 32'(act), 32'(exp));
               check($sformatf("bit_hold_u%0d", u), 32'(glitch), 32'd0);
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   // Issue one byte on the first idle cycle and measure the TI-low window.
   // With inject set, 8'hFF strobes land mid-frame and on the last STOP cycle.
   task automatic send(input int u, input logic [7:0] b, input bit inject);
      int   f;
      int   lowc;
      int   w;
      logic ti;
      f = (u == 0) ? F1 : F2;
      lowc = 0;
      w = 0;
      while (get_ti(u) !== 1'b1 && w < 200) begin
         @(negedge clock);
         w++;
      end
      check($sformatf("ti_idle_before_wr_u%0d", u), 32'(get_ti(u)), 32'd1);
      if (u == 0) q0.push_back(frame_of(b, 1));
      else        q1.push_back(frame_of(b, 2));
      drive(u, 1'b1, b);
      @(posedge clock);
      for (int n = 1; n <= f + 50; n++) begin
         @(negedge clock);
         ti = get_ti(u);
         if (inject && (n == 20 || n == f)) drive(u, 1'b1, 8'hFF);
         else                               drive(u, 1'b0, 8'($urandom));
         if (ti === 1'b1) break;
         lowc++;
      end
      check($sformatf("ti_low_cycles_u%0d_%02h", u, b), 32'(lowc), 32'(f));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);

      // Reset values and quiet line after release.
      repeat (5) @(negedge clock);
      check("rst_txd_u0", 32'(bus0.txd), 32'd1);
      check("rst_ti_u0",  32'(bus0.TI),  32'd1);
      check("rst_txd_u1", 32'(bus1.txd), 32'd1);
      check("rst_ti_u1",  32'(bus1.TI),  32'd1);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (bus0.txd !== 1'b1 || bus0.TI !== 1'b1 ||
             bus1.txd !== 1'b1 || bus1.TI !== 1'b1) bad++;
      end
      check("idle_after_reset", 32'(bad), 32'd0);

      // Single byte and parity patterns.
      send(0, 8'hA5, 1'b0);
      send(0, 8'h07, 1'b0);
      send(0, 8'h03, 1'b0);

      // Strobes mid-frame and on the last STOP cycle must be dropped.
      send(0, 8'h00, 1'b1);

      // Back-to-back frames, one and two stop bits.
      send(0, 8'h01, 1'b0);
      send(0, 8'h80, 1'b0);
      send(0, 8'h55, 1'b0);
      send(1, 8'h01, 1'b0);
      send(1, 8'h80, 1'b0);
      send(1, 8'h55, 1'b0);
      send(1, 8'h00, 1'b1);

      // Reset during DATA bit 3 (a 0 bit) aborts the frame asynchronously.
      q0.push_back(frame_of(8'h36, 1));
      drive(0, 1'b1, 8'h36);
      @(posedge clock);
      for (int n = 1; n < 18; n++) begin
         @(negedge clock);
         drive(0, 1'b0, 8'h00);
      end
      @(negedge clock);
      check("pre_reset_ti_busy", 32'(bus0.TI), 32'd0);
      rst_n = 1'b0;
      #1;
      check("async_rst_txd", 32'(bus0.txd), 32'd1);
      check("async_rst_ti",  32'(bus0.TI),  32'd1);
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      send(0, 8'hC3, 1'b0);

      repeat (20) @(negedge clock);
      check("queue_drained_u0", 32'(q0.size()), 32'd0);
      check("queue_drained_u1", 32'(q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
